// File: rtl/ch0re_mem_arbiter.sv
// ch0re_mem_arbiter: arbitrates a fetch and a data requester onto one memory port, one outstanding transaction.
// Define CH0RE_ARB_STARVE_EN to force a fetch win after STARVE_MAX consecutive fetch losses.
module ch0re_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
    state_t state;
    logic   owner_d;
    logic   fetch_win;
    logic   gnt_now;
    logic   rsp_now;
`ifdef CH0RE_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve;
    // Counter never exceeds STARVE_MAX: reaching it makes fetch win, which clears it.
    assign fetch_win = i_req && (!d_req || starve == CNT_W'(STARVE_MAX));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve <= '0;
        else if (state == IDLE && i_req)
            starve <= fetch_win ? '0 : starve + 1'b1;
    end
`else
    assign fetch_win = i_req && !d_req;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (i_req || d_req) begin
                    state   <= ISSUE;
                    m_req   <= 1'b1;
                    owner_d <= !fetch_win;
                    m_we    <= fetch_win ? 1'b0 : d_we;
                    m_be    <= fetch_win ? '1 : d_be;
                    m_addr  <= fetch_win ? i_addr : d_addr;
                    m_wdata <= fetch_win ? '0 : d_wdata;
                end
                ISSUE: if (m_gnt) begin
                    state <= WAIT_RSP;
                    m_req <= 1'b0;
                end
                WAIT_RSP: if (m_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign gnt_now  = state == ISSUE && m_gnt;
    assign rsp_now  = state == WAIT_RSP && m_rvalid;
    assign i_gnt    = gnt_now && !owner_d;
    assign d_gnt    = gnt_now && owner_d;
    assign i_rvalid = rsp_now && !owner_d;
    assign d_rvalid = rsp_now && owner_d;
    assign rdata    = rsp_now ? m_rdata : '0;
endmodule

// File: tb/tb_ch0re_mem_arbiter.sv
// tb_ch0re_mem_arbiter: vector table, corner-case sequences and randomized traffic against a transaction-level model.
module tb_ch0re_mem_arbiter;
`ifdef CH0RE_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif
    localparam int STARVE_MAX = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [3:0]  d_be = '0;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, rdata;
    int vectors = 0;
    int miscompares = 0;
    int starve = 0;

    ch0re_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] rdv;
        int          gd;
        int          rd;
        logic        exp_d;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " m_req"}, m_req, 0);
        chk({tag, " m_we"}, m_we, 0);
        chk({tag, " m_be"}, m_be, 0);
        chk({tag, " m_addr"}, m_addr, 0);
        chk({tag, " m_wdata"}, m_wdata, 0);
        chk({tag, " gnts"}, {i_gnt, d_gnt}, 0);
        chk({tag, " rvalids"}, {i_rvalid, d_rvalid}, 0);
        chk({tag, " rdata"}, rdata, 0);
    endtask

    task automatic chk_m(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        chk("issue m_req", m_req, 1);
        chk("issue m_we", m_we, we);
        chk("issue m_be", m_be, be);
        chk("issue m_addr", m_addr, addr);
        chk("issue m_wdata", m_wdata, wdata);
        chk("issue rvalids", {i_rvalid, d_rvalid}, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Requests must already be driven; starts and ends at a negedge with the DUT idle.
    task automatic run_txn(input int gd, input int rd, input logic [31:0] rdv, input logic exp_d,
                           input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input bit noise);
        cyc();
        for (int k = 0; k < gd; k++) begin
            m_gnt = 1'b0;
            m_rvalid = noise ? 1'($urandom) : 1'b0;
            m_rdata = $urandom;
            #1;
            chk_m(exp_we, exp_be, exp_addr, exp_wdata);
            chk("stall gnts", {i_gnt, d_gnt}, 0);
            cyc();
        end
        m_gnt = 1'b1;
        m_rvalid = noise ? 1'($urandom) : 1'b0;
        #1;
        chk_m(exp_we, exp_be, exp_addr, exp_wdata);
        chk("i_gnt", i_gnt, !exp_d);
        chk("d_gnt", d_gnt, exp_d);
        cyc();
        m_gnt = 1'b0;
        m_rvalid = 1'b0;
        if (exp_d) d_req = 1'b0;
        else i_req = 1'b0;
        for (int k = 0; k < rd; k++) begin
            m_gnt = noise ? 1'($urandom) : 1'b0;
            #1;
            chk("wait m_req", m_req, 0);
            chk("wait gnts", {i_gnt, d_gnt}, 0);
            chk("wait rvalids", {i_rvalid, d_rvalid}, 0);
            cyc();
        end
        m_gnt = noise ? 1'($urandom) : 1'b0;
        m_rvalid = 1'b1;
        m_rdata = rdv;
        #1;
        chk("i_rvalid", i_rvalid, !exp_d);
        chk("d_rvalid", d_rvalid, exp_d);
        chk("rdata", rdata, rdv);
        chk("rsp gnts", {i_gnt, d_gnt}, 0);
        cyc();
        m_gnt = 1'b0;
        m_rvalid = 1'b0;
    endtask

    // Model: data beats fetch unless fetch has already lost STARVE_MAX times in a row.
    task automatic arb(output bit fetch);
        if (i_req && d_req && !(STARVE_EN && starve >= STARVE_MAX)) begin
            fetch = 1'b0;
            starve = starve + 1;
        end else begin
            fetch = i_req;
            if (i_req) starve = 0;
        end
    endtask

    task automatic run_pending(input int gd, input int rd, input logic [31:0] rdv, input bit noise);
        bit f;
        arb(f);
        run_txn(gd, rd, rdv, !f, f ? 1'b0 : d_we, f ? 4'hF : d_be, f ? i_addr : d_addr,
                f ? 32'h0 : d_wdata, noise);
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h150, 1'b0, 4'h0, 32'h0, 32'h0, 32'h13, 0, 0, 1'b0, 1'b0, 4'hF, 32'h150, 32'h0};
        tbl[1] = '{1'b0, 32'h0, 1'b0, 4'h3, 32'h2004, 32'h1234, 32'hCAFEF00D, 1, 2, 1'b1, 1'b0, 4'h3, 32'h2004, 32'h1234};
        tbl[2] = '{1'b0, 32'h0, 1'b1, 4'hF, 32'h2000, 32'hDEADBEEF, 32'h0, 0, 0, 1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 32'h80000000, 1'b0, 4'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 3, 0, 1'b0, 1'b0, 4'hF, 32'h80000000, 32'h0};
        tbl[4] = '{1'b0, 32'h0, 1'b1, 4'h8, 32'hFFFFFFFC, 32'hA5A5A5A5, 32'h0, 2, 3, 1'b1, 1'b1, 4'h8, 32'hFFFFFFFC, 32'hA5A5A5A5};
        tbl[5] = '{1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0BADCAFE, 0, 1, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0};
        @(negedge clk);
        chk_zero("in reset");
        cyc();
        rst = 1'b0;
        cyc();
        chk_zero("after reset");

        for (int i = 0; i < 6; i++) begin
            i_req = tbl[i].ireq;
            i_addr = tbl[i].iaddr;
            d_req = !tbl[i].ireq;
            d_we = tbl[i].dwe;
            d_be = tbl[i].dbe;
            d_addr = tbl[i].daddr;
            d_wdata = tbl[i].dwdata;
            run_txn(tbl[i].gd, tbl[i].rd, tbl[i].rdv, tbl[i].exp_d, tbl[i].exp_we, tbl[i].exp_be,
                    tbl[i].exp_addr, tbl[i].exp_wdata, 1'b0);
        end

        // Simultaneous requests: data first, fetch in the next transaction.
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
        run_txn(0, 0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEADBEEF, 1'b0);
        run_txn(0, 0, 32'h77, 1'b0, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0);

        // Fetch held against a data stream: wins the 5th arbitration only with the guard.
        i_req = 1'b1; i_addr = 32'h444;
        for (int n = 1; n <= 5; n++) begin
            bit fw;
            fw = STARVE_EN && n == 5;
            d_req = 1'b1; d_we = 1'b0; d_be = 4'h3; d_addr = 32'h1000 + n; d_wdata = n;
            run_txn(0, 0, 32'h10 + n, !fw, 1'b0, fw ? 4'hF : 4'h3, fw ? 32'h444 : 32'h1000 + n,
                    fw ? 32'h0 : 32'(n), 1'b0);
        end
        starve = 0;
        for (int n = 0; n < 2; n++)
            if (i_req || d_req) run_pending(1, 1, 32'h5A5A0000 + n, 1'b0);

        for (int t = 0; t < 150; t++) begin
            if (!i_req && $urandom_range(1, 0) == 1) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (!d_req && $urandom_range(1, 0) == 1) begin
                d_req = 1'b1; d_we = 1'($urandom); d_be = 4'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            if (!i_req && !d_req) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            run_pending($urandom_range(3, 0), $urandom_range(3, 0), $urandom, 1'b1);
        end
        for (int n = 0; n < 2; n++)
            if (i_req || d_req) run_pending(0, 0, $urandom, 1'b1);

        // Reset while waiting for a response abandons the transaction.
        i_req = 1'b1; i_addr = 32'hABC0;
        cyc();
        m_gnt = 1'b1;
        cyc();
        m_gnt = 1'b0; i_req = 1'b0;
        #1;
        chk("pre-reset m_addr", m_addr, 32'hABC0);
        rst = 1'b1;
        #1;
        chk_zero("mid reset");
        cyc();
        rst = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h55;
        #1;
        chk_zero("stale rvalid");
        cyc();
        m_rvalid = 1'b0;
        chk("post reset m_req", m_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
